// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALUop codes, RV32 opcode and
// funct fields, FSM state encoding and the I-type immediate sign extension.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b1001;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b1101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue-side and result-side valid/ready channels of the ALU issue controller.
// master = upstream issue logic / result consumer, slave = the controller.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  modport master (
    output in_valid, instr, rs1_val, rs2_val, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, instr, rs1_val, rs2_val, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32 R/I-type ALU decode: instruction word to ALUop, operand-2
// source select, sign-extended immediate and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  // register index fields are consumed by the register file and the top
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // R-type needs an exact funct7 so that M-extension and SRA encodings fall out as illegal
  always_comb begin
    alu_op  = ALU_NOP;
    use_imm = 1'b0;
    imm     = sext12(instr[31:20]);
    illegal = 1'b1;
    case (opcode)
      OPC_R: begin
        case (f3)
          F3_ADD: begin
            if (f7 == F7_ZERO) begin
              alu_op  = ALU_ADD;
              illegal = 1'b0;
            end else if (f7 == F7_ALT) begin
              alu_op  = ALU_SUB;
              illegal = 1'b0;
            end
          end
          F3_XOR: if (f7 == F7_ZERO) begin alu_op = ALU_XOR; illegal = 1'b0; end
          F3_OR:  if (f7 == F7_ZERO) begin alu_op = ALU_OR;  illegal = 1'b0; end
          F3_AND: if (f7 == F7_ZERO) begin alu_op = ALU_AND; illegal = 1'b0; end
          F3_SLL: if (f7 == F7_ZERO) begin alu_op = ALU_SLL; illegal = 1'b0; end
          F3_SRL: if (f7 == F7_ZERO) begin alu_op = ALU_SRL; illegal = 1'b0; end
          default: ;
        endcase
      end
      OPC_I: begin
        use_imm = 1'b1;
        case (f3)
          F3_ADD: begin alu_op = ALU_ADD; illegal = 1'b0; end
          F3_XOR: begin alu_op = ALU_XOR; illegal = 1'b0; end
          F3_OR:  begin alu_op = ALU_OR;  illegal = 1'b0; end
          F3_AND: begin alu_op = ALU_AND; illegal = 1'b0; end
          F3_SLL: if (f7 == F7_ZERO) begin alu_op = ALU_SLL; illegal = 1'b0; end
          F3_SRL: if (f7 == F7_ZERO) begin alu_op = ALU_SRL; illegal = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (illegal) begin
      use_imm = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction, drives a registered ALU,
// waits out its latency and returns the result with rd. One op in flight.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for in_valid; ALU inputs hold last values
// ST_EXEC | ALU inputs stable, latency counter running down to zero
// ST_DONE | out_valid=1, result/rd/illegal held until out_ready
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [31:0]       alu_rs1,
  output logic [31:0]       alu_rs2,
  output logic [3:0]        alu_op,
  input  logic [31:0]       alu_result
);

  localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        alu_rs1_q, alu_rs1_d;
  logic [31:0]        alu_rs2_q, alu_rs2_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [31:0]        out_result_q, out_result_d;
  logic [4:0]         out_rd_q, out_rd_d;
  logic               out_illegal_q, out_illegal_d;

  logic [3:0]         dec_op;
  logic               dec_use_imm;
  logic [31:0]        dec_imm;
  logic               dec_illegal;
  logic               accept;
  logic               exec_last;

  alu_op_decode u_decode (
    .instr   (bus.instr),
    .alu_op  (dec_op),
    .use_imm (dec_use_imm),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign exec_last = (state_q == ST_EXEC) && (cnt_q == '0);

  // FSM state register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: illegal instructions skip EXEC and report immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = dec_illegal ? ST_DONE : ST_EXEC;
      ST_EXEC: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals are pure functions of the state
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
  end

  // Datapath next values: capture operands on accept, result on the last EXEC edge
  always_comb begin
    cnt_d         = cnt_q;
    alu_rs1_d     = alu_rs1_q;
    alu_rs2_d     = alu_rs2_q;
    alu_op_d      = alu_op_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    if (accept) begin
      alu_rs1_d     = bus.rs1_val;
      alu_rs2_d     = dec_use_imm ? dec_imm : bus.rs2_val;
      alu_op_d      = dec_illegal ? ALU_NOP : dec_op;
      out_rd_d      = bus.instr[11:7];
      out_illegal_d = dec_illegal;
      out_result_d  = '0;
      cnt_d         = CNT_W'(ALU_LAT);
    end else if (exec_last) begin
      out_result_d = alu_result;
    end else if (state_q == ST_EXEC) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      alu_rs1_q     <= '0;
      alu_rs2_q     <= '0;
      alu_op_q      <= ALU_NOP;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      alu_rs1_q     <= alu_rs1_d;
      alu_rs2_q     <= alu_rs2_d;
      alu_op_q      <= alu_op_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_rs1         = alu_rs1_q;
  assign alu_rs2         = alu_rs2_q;
  assign alu_op          = alu_op_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_illegal = out_illegal_q;

endmodule
